lab1_imul_int_div_iterative: RTL and testbench
==============================================

// Module: lab1_imul_int_div_iterative
//
// PURPOSE
//   Iterative unsigned integer divider: the inverse of the lab1 multipliers.
//   Accepts {dividend, divisor} on a val/rdy input stream and returns
//   {quotient, remainder} on a val/rdy output stream.
//   Uses restoring shift-subtract division, one quotient bit per cycle.
//   Has the same stream interface style as the imul blocks, so the same
//   test sources and sinks drive it.
//
// PARAMETERS
//   NBITS  32  operand width; istream_msg is 2*NBITS bits, ostream_msg is 2*NBITS bits
//
// PORTS
//   clk          in   1        clock
//   reset        in   1        reset, synchronous, active-high
//   istream_val  in   1        input message valid
//   istream_rdy  out  1        input message ready
//   istream_msg  in   2*NBITS  [2N-1:N] dividend, [N-1:0] divisor
//   ostream_val  out  1        result valid
//   ostream_rdy  in   1        result ready
//   ostream_msg  out  2*NBITS  [2N-1:N] quotient, [N-1:0] remainder
//
// BEHAVIOUR
//   - FSM states: IDLE, CALC, DONE. istream_rdy = (state==IDLE) and
//     ostream_val = (state==DONE). Both are decoded combinationally from the
//     state register.
//   - Reset: state<=IDLE, counter<=0, quotient/remainder/divisor regs<=0.
//     After the reset edge: istream_rdy=1, ostream_val=0, ostream_msg=0.
//     Reset in any state, including mid-CALC or DONE, aborts the operation.
//     The result is lost and no output is produced.
//   - Transfers happen only on a clock edge where val && rdy are both 1.
//   - IDLE, on input transfer:
//       - divisor!=0: load quo<=dividend, rem<=0, div<=divisor, cnt<=NBITS;
//         go to CALC.
//       - divisor==0: load quo<=all ones, rem<=dividend; go to DONE directly.
//         This matches RISC-V DIVU/REMU semantics.
//   - CALC, each cycle:
//       - {rem,quo} <<= 1.
//       - t = rem_shifted - div, computed NBITS+1 wide.
//       - If t is non-negative (MSB 0): rem<=t[N-1:0], quo[0]<=1.
//         Otherwise rem is kept and quo[0]<=0.
//       - cnt<=cnt-1. When cnt==1 at the edge, go to DONE.
//   - Latency (transfer edge to first cycle with ostream_val=1):
//       - divisor!=0: exactly NBITS+1 cycles.
//       - divisor==0: 1 cycle.
//   - DONE: hold ostream_msg={quo,rem} stable while ostream_rdy=0
//     (backpressure). On the output transfer edge go to IDLE.
//   - Overlap: input and output transfers never overlap.
//     istream_rdy=0 in CALC/DONE.
//     Maximum throughput is one result per NBITS+2 cycles.
//   - IDLE with istream_val=0: remain in IDLE. Registers hold their values.
//   - Arithmetic: unsigned only; the quotient never overflows.
//     Edge cases: dividend<divisor gives q=0, r=dividend; dividend==0 gives
//     q=0, r=0 (full NBITS cycles, no early exit).
//   - X-safety: istream_msg is ignored unless istream_val && istream_rdy.
//     ostream_rdy is ignored outside DONE.
//   - Line trace format: istream val/rdy/msg | (IDLE|CALC|DONE, cnt) |
//     ostream val/rdy/msg.
//
// STRUCTURE
//   - Shared package lab1_imul_pkg holds:
//       - typedef enum logic [1:0] {IDLE, CALC, DONE} imul_state_t, shared
//         with the multipliers.
//       - localparam for the counter width, $clog2(NBITS)+1.
//   - One sub-module, lab1_imul_int_div_dpath, holds the quo/rem/div
//     registers, the NBITS+1-bit subtractor (vc_Subtractor) and the
//     zero-divisor detect.
//   - Control (FSM, counter, handshake decode) lives in this module and
//     drives the dpath muxes with load/step/zero_load controls.
//
// TESTING
//   1. 100/7: msg=0x00000064_00000007 -> 0x0000000E_00000002.
//      ostream_val rises exactly 33 cycles after the transfer edge.
//   2. Boundary operands:
//      - 7/100 -> 0x00000000_00000007
//      - 0xFFFFFFFF/1 -> 0xFFFFFFFF_00000000
//      - 0/5 -> 0x00000000_00000000
//   3. Divide by zero: 5/0 -> 0xFFFFFFFF_00000005 with 1-cycle latency.
//      The next input is accepted afterwards with a correct result.
//   4. Backpressure: 100/7 with ostream_rdy=0 for 5 cycles in DONE.
//      ostream_val stays 1, msg stays stable, istream_rdy stays 0; the result
//      is consumed exactly once.
//   5. Reset asserted on CALC cycle 10 -> next cycle IDLE, istream_rdy=1,
//      ostream_val=0. A following 9/3 returns 0x00000003_00000000.
//   6. 500 random operands (10% zero divisors) with random src/sink delays
//      0-5, checked in order against a {a/b, a%b} reference model.

Source files
------------

// File: rtl/lab1_imul_pkg.sv
// Types and sizing shared by the lab1 multiplier/divider blocks.
package lab1_imul_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } imul_state_t;

   localparam int unsigned NBITS_DEFAULT = 32;
   localparam int unsigned CNT_W         = $clog2(NBITS_DEFAULT) + 1;

   // Counter must hold the value NBITS itself, hence the extra bit.
   function automatic int unsigned cnt_width(input int unsigned nbits);
      return $clog2(nbits) + 1;
   endfunction

endpackage

// File: rtl/lab1_imul_int_div_iterative_if.sv
// Input/output val/rdy streams of the iterative divider.
interface lab1_imul_int_div_iterative_if #(
   parameter int unsigned NBITS = 32
);
   logic               istream_val;
   logic               istream_rdy;
   logic [2*NBITS-1:0] istream_msg;
   logic               ostream_val;
   logic               ostream_rdy;
   logic [2*NBITS-1:0] ostream_msg;

   modport master (
      output istream_val, istream_msg, ostream_rdy,
      input  istream_rdy, ostream_val, ostream_msg
   );

   modport slave (
      input  istream_val, istream_msg, ostream_rdy,
      output istream_rdy, ostream_val, ostream_msg
   );
endinterface

// File: rtl/lab1_imul_int_div_dpath.sv
// Divider datapath: quotient/remainder/divisor registers and the restoring
// shift-subtract step.
module lab1_imul_int_div_dpath #(
   parameter int unsigned NBITS = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_i,
   input  logic             zero_load_i,
   input  logic             step_i,
   input  logic [NBITS-1:0] dividend_i,
   input  logic [NBITS-1:0] divisor_i,
   output logic             div_zero_o,
   output logic [NBITS-1:0] quo_o,
   output logic [NBITS-1:0] rem_o
);

   logic [NBITS-1:0] quo_q, quo_d;
   logic [NBITS-1:0] rem_q, rem_d;
   logic [NBITS-1:0] div_q, div_d;
   logic [NBITS:0]   rem_sh;
   logic [NBITS-1:0] quo_sh;
   logic [NBITS:0]   diff;

   assign div_zero_o = (divisor_i == '0);

   // Remainder is shifted NBITS+1 wide: with a large divisor the shifted
   // remainder can exceed NBITS bits before the subtract brings it back.
   assign rem_sh = {rem_q, quo_q[NBITS-1]};
   assign quo_sh = {quo_q[NBITS-2:0], 1'b0};
   assign diff   = rem_sh - {1'b0, div_q};

   always_comb begin
      quo_d = quo_q;
      rem_d = rem_q;
      div_d = div_q;
      if (load_i) begin
         quo_d = dividend_i;
         rem_d = '0;
         div_d = divisor_i;
      end else if (zero_load_i) begin
         quo_d = '1;
         rem_d = dividend_i;
      end else if (step_i) begin
         if (!diff[NBITS]) begin
            rem_d = diff[NBITS-1:0];
            quo_d = quo_sh | {{(NBITS-1){1'b0}}, 1'b1};
         end else begin
            rem_d = rem_sh[NBITS-1:0];
            quo_d = quo_sh;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         quo_q <= '0;
         rem_q <= '0;
         div_q <= '0;
      end else begin
         quo_q <= quo_d;
         rem_q <= rem_d;
         div_q <= div_d;
      end
   end

   assign quo_o = quo_q;
   assign rem_o = rem_q;

endmodule

// File: rtl/lab1_imul_int_div_iterative.sv
// Iterative unsigned divider: control FSM, bit counter and stream handshakes.
module lab1_imul_int_div_iterative
   import lab1_imul_pkg::*;
#(
   parameter int unsigned NBITS = 32
) (
   input logic                          clk,
   input logic                          reset,
   lab1_imul_int_div_iterative_if.slave ifc
);

   localparam int unsigned CntW = cnt_width(NBITS);

   imul_state_t     state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            in_xfer;
   logic            div_zero;
   logic            load;
   logic            zero_load;
   logic            step;
   logic [NBITS-1:0] quo;
   logic [NBITS-1:0] rem;

   assign ifc.istream_rdy = (state_q == IDLE);
   assign ifc.ostream_val = (state_q == DONE);
   assign ifc.ostream_msg = {quo, rem};

   assign in_xfer   = ifc.istream_val && ifc.istream_rdy;
   assign load      = in_xfer && !div_zero;
   assign zero_load = in_xfer && div_zero;
   assign step      = (state_q == CALC);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (in_xfer) begin
               if (div_zero) begin
                  state_d = DONE;
               end else begin
                  state_d = CALC;
                  cnt_d   = CntW'(NBITS);
               end
            end
         end
         CALC: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CntW'(1)) state_d = DONE;
         end
         DONE: begin
            if (ifc.ostream_rdy) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   lab1_imul_int_div_dpath #(
      .NBITS (NBITS)
   ) u_dpath (
      .clk         (clk),
      .reset       (reset),
      .load_i      (load),
      .zero_load_i (zero_load),
      .step_i      (step),
      .dividend_i  (ifc.istream_msg[2*NBITS-1:NBITS]),
      .divisor_i   (ifc.istream_msg[NBITS-1:0]),
      .div_zero_o  (div_zero),
      .quo_o       (quo),
      .rem_o       (rem)
   );

endmodule

// File: tb/tb_lab1_imul_int_div_iterative.sv
// Self-checking bench for the iterative divider: directed literal cases plus
// randomized traffic against a {a/b, a%b} reference model.
module tb_lab1_imul_int_div_iterative;

   localparam int unsigned N = 32;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic rand_sink = 1'b0;
   logic rand_rdy = 1'b0;
   logic dir_rdy = 1'b0;

   int checks = 0;
   int errors = 0;

   lab1_imul_int_div_iterative_if #(.NBITS(N)) ifc ();

   lab1_imul_int_div_iterative #(
      .NBITS (N)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .ifc   (ifc)
   );

   always #5 clk = ~clk;

   assign ifc.ostream_rdy = rand_sink ? rand_rdy : dir_rdy;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b);
      if (b == 0) return {32'hFFFF_FFFF, a};
      return {a / b, a % b};
   endfunction

   // Reference model: queue of expected results and the latency they are due at.
   logic [63:0] exp_q[$];
   bit          busy = 0;
   int          wait_cnt = 0;
   int          exp_lat = 0;
   int          n_recv = 0;

   always @(negedge clk) begin
      if (reset) begin
         exp_q.delete();
         busy = 0;
      end else begin
         check("istream_rdy", 64'(ifc.istream_rdy), 64'(!busy));
         if (busy) begin
            wait_cnt++;
            check("ostream_val_timing", 64'(ifc.ostream_val), 64'(wait_cnt >= exp_lat));
            if (ifc.ostream_val) begin
               check("ostream_msg", ifc.ostream_msg, exp_q[0]);
               if (ifc.ostream_rdy) begin
                  void'(exp_q.pop_front());
                  busy = 0;
                  n_recv++;
               end
            end
         end else begin
            check("ostream_val_idle", 64'(ifc.ostream_val), 64'd0);
         end
         if (ifc.istream_val && ifc.istream_rdy) begin
            exp_q.push_back(ref_div(ifc.istream_msg[63:32], ifc.istream_msg[31:0]));
            busy     = 1;
            wait_cnt = 0;
            exp_lat  = (ifc.istream_msg[31:0] == 0) ? 1 : N + 1;
         end
      end
   end

   always begin
      @(posedge clk);
      #1;
      if (rand_sink) rand_rdy = ($urandom_range(0, 5) == 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
   end

   // Caller is at posedge+#1; returns at posedge+#1 just after the transfer edge.
   task automatic send(input logic [31:0] a, input logic [31:0] b);
      int guard;
      guard = 0;
      ifc.istream_val = 1'b1;
      ifc.istream_msg = {a, b};
      forever begin
         @(negedge clk);
         if (ifc.istream_rdy) break;
         guard++;
         if (guard > 200) begin
            check("send_timeout", 64'd0, 64'd1);
            break;
         end
      end
      @(posedge clk);
      #1;
      ifc.istream_val = 1'b0;
      ifc.istream_msg = {$urandom, $urandom};
   endtask

   // Waits for the result, checks value and latency, holds it hold_cyc cycles, consumes it.
   task automatic get_result(input string name, input logic [63:0] exp, input int exp_l,
                             input int hold_cyc);
      int lat;
      int recv0;
      logic [63:0] first_msg;
      lat = 1;
      forever begin
         @(negedge clk);
         if (ifc.ostream_val) break;
         lat++;
         if (lat > 100) break;
      end
      check({name, "_lat"}, 64'(lat), 64'(exp_l));
      check({name, "_msg"}, ifc.ostream_msg, exp);
      first_msg = ifc.ostream_msg;
      recv0 = n_recv;
      for (int i = 0; i < hold_cyc; i++) begin
         @(posedge clk);
         #1;
         @(negedge clk);
         check({name, "_bp_val"}, 64'(ifc.ostream_val), 64'd1);
         check({name, "_bp_msg"}, ifc.ostream_msg, first_msg);
         check({name, "_bp_irdy"}, 64'(ifc.istream_rdy), 64'd0);
      end
      @(posedge clk);
      #1;
      dir_rdy = 1'b1;
      @(posedge clk);
      #1;
      dir_rdy = 1'b0;
      if (hold_cyc > 0) begin
         @(negedge clk);
         check({name, "_consumed_once"}, 64'(n_recv - recv0), 64'd1);
         check({name, "_val_after"}, 64'(ifc.ostream_val), 64'd0);
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      int sent;
      int recv_base;
      int guard;
      logic [31:0] a;
      logic [31:0] b;

      ifc.istream_val = 1'b0;
      ifc.istream_msg = '0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("reset_irdy", 64'(ifc.istream_rdy), 64'd1);
      check("reset_oval", 64'(ifc.ostream_val), 64'd0);
      check("reset_omsg", ifc.ostream_msg, 64'd0);
      @(posedge clk);
      #1;

      send(32'd100, 32'd7);
      get_result("div_100_7", 64'h0000000E_00000002, 33, 0);
      send(32'd7, 32'd100);
      get_result("div_7_100", 64'h00000000_00000007, 33, 0);
      send(32'hFFFF_FFFF, 32'd1);
      get_result("div_max_1", 64'hFFFFFFFF_00000000, 33, 0);
      send(32'd0, 32'd5);
      get_result("div_0_5", 64'h00000000_00000000, 33, 0);
      send(32'hFFFF_FFFF, 32'h8000_0001);
      get_result("div_big_divisor", 64'h00000001_7FFFFFFE, 33, 0);
      send(32'd5, 32'd0);
      get_result("div_by_zero", 64'hFFFFFFFF_00000005, 1, 0);
      send(32'd100, 32'd7);
      get_result("after_zero", 64'h0000000E_00000002, 33, 0);

      send(32'd100, 32'd7);
      get_result("backpressure", 64'h0000000E_00000002, 33, 5);

      // Abort on CALC cycle 10.
      send(32'd100, 32'd7);
      repeat (9) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("abort_irdy", 64'(ifc.istream_rdy), 64'd1);
      check("abort_oval", 64'(ifc.ostream_val), 64'd0);
      @(posedge clk);
      #1;
      send(32'd9, 32'd3);
      get_result("div_9_3", 64'h00000003_00000000, 33, 0);

      // Randomized traffic with random source gaps and sink stalls.
      recv_base = n_recv;
      rand_sink = 1'b1;
      sent = 0;
      for (int i = 0; i < 500; i++) begin
         repeat ($urandom_range(0, 5)) begin
            @(posedge clk);
            #1;
         end
         a = $urandom >> $urandom_range(0, 31);
         if ($urandom_range(0, 9) == 0) begin
            b = 32'd0;
         end else begin
            b = $urandom >> $urandom_range(0, 31);
            if (b == 0) b = 32'd1;
         end
         send(a, b);
         sent++;
      end
      guard = 0;
      while ((n_recv - recv_base) < sent && guard < 500) begin
         @(posedge clk);
         guard++;
      end
      #1;
      check("random_all_received", 64'(n_recv - recv_base), 64'(sent));
      rand_sink = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
